// File: rtl/cdda_ctrl.sv
// cdda_ctrl -- CD-DA playback controller.
//
// Moves 2352-byte sectors (1176 16-bit words) from the sector buffer into
// the CD-DA sample FIFO. A new sector is started only when the FIFO reports
// room for a whole sector. Also generates the 44.1 kHz FIFO read strobe from
// a fractional accumulator and runs the play/pause/resume/stop mode machine.
// Stop is sector-aligned and flushes the FIFO.
//
// Handshakes:
//   CMD_VALID/CMD_READY: a command is taken on a rising CLK edge where both
//   are high. SECTOR_VALID/SECTOR_ACK: the source holds SECTOR_VALID while a
//   full sector is present. It must drop or refresh it by the cycle after the
//   one-cycle SECTOR_ACK pulse. SRC_RD/SRC_DATA: SRC_DATA is valid the cycle
//   after SRC_RD.
//
// Ports:
//   CLK, nRESET            clock, asynchronous active-low reset
//   CMD_VALID, CMD[1:0]    command strobe / code (00 stop, 01 play,
//                          10 pause, 11 resume)
//   CMD_READY              command accepted (low only while STOPPING)
//   SECTOR_VALID           full sector available in the source buffer
//   SECTOR_ACK             pulse after the last word of a sector is written
//   SRC_RD, SRC_ADDR       source read strobe / word address 0..1175
//   SRC_DATA               source word
//   FIFO_WRITE, FIFO_DIN   FIFO write strobe / data
//   FIFO_WRITE_READY       FIFO has room for one full sector
//   FIFO_READ              sample read strobe
//   FIFO_nRESET            FIFO flush, active-low
//   PLAYING                mode is PLAYING
//   SECTORS_DONE           completed sector count (wraps)
module cdda_ctrl #(
    parameter int unsigned CLK_FREQ    = 96000000,
    parameter int unsigned SAMPLE_RATE = 44100
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        CMD_VALID,
    input  logic [1:0]  CMD,
    output logic        CMD_READY,
    input  logic        SECTOR_VALID,
    output logic        SECTOR_ACK,
    output logic        SRC_RD,
    output logic [10:0] SRC_ADDR,
    input  logic [15:0] SRC_DATA,
    output logic        FIFO_WRITE,
    output logic [15:0] FIFO_DIN,
    input  logic        FIFO_WRITE_READY,
    output logic        FIFO_READ,
    output logic        FIFO_nRESET,
    output logic        PLAYING,
    output logic [15:0] SECTORS_DONE
);

    typedef enum logic [1:0] {
        M_STOPPED  = 2'd0,
        M_PLAYING  = 2'd1,
        M_PAUSED   = 2'd2,
        M_STOPPING = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        T_IDLE = 3'd0,
        T_RD   = 3'd1,
        T_LAT  = 3'd2,
        T_WR   = 3'd3,
        T_ACK  = 3'd4
    } xfer_t;

    localparam logic [1:0]  CMD_STOP   = 2'b00;
    localparam logic [1:0]  CMD_PLAY   = 2'b01;
    localparam logic [1:0]  CMD_PAUSE  = 2'b10;
    localparam logic [1:0]  CMD_RESUME = 2'b11;
    localparam logic [10:0] LAST_ADDR  = 11'd1175;

    mode_t       mode_q, mode_d;
    xfer_t       xfer_q, xfer_d;
    logic [10:0] addr_d;
    logic        cmd_accept;
    logic        stop_accept;
    logic        active;

    logic [31:0] acc_q;
    logic [32:0] acc_sum;
    logic [31:0] acc_d;
    logic        tick;

    // ------------------------------------------------------------------
    // Mode FSM
    // ------------------------------------------------------------------
    always_comb begin
        mode_d      = mode_q;
        cmd_accept  = CMD_VALID && CMD_READY;
        active      = (mode_q == M_PLAYING) || (mode_q == M_PAUSED);
        stop_accept = cmd_accept && (CMD == CMD_STOP) && active;

        case (mode_q)
            M_STOPPED: begin
                if (cmd_accept && (CMD == CMD_PLAY))
                    mode_d = M_PLAYING;
            end
            M_PLAYING: begin
                if (cmd_accept && (CMD == CMD_PAUSE))
                    mode_d = M_PAUSED;
            end
            M_PAUSED: begin
                if (cmd_accept && ((CMD == CMD_PLAY) || (CMD == CMD_RESUME)))
                    mode_d = M_PLAYING;
            end
            M_STOPPING: begin
                if (xfer_q == T_IDLE)
                    mode_d = M_STOPPED;
            end
            default: mode_d = M_STOPPED;
        endcase

        // A stop never aborts a sector: wait in STOPPING until it completes.
        if (stop_accept)
            mode_d = (xfer_q == T_IDLE) ? M_STOPPED : M_STOPPING;
    end

    // ------------------------------------------------------------------
    // Transfer FSM
    // ------------------------------------------------------------------
    always_comb begin
        xfer_d = xfer_q;
        addr_d = SRC_ADDR;

        case (xfer_q)
            T_IDLE: begin
                // A stop taken this cycle goes straight to STOPPED, so a
                // sector must not be started behind it.
                if (active && !stop_accept && SECTOR_VALID && FIFO_WRITE_READY) begin
                    xfer_d = T_RD;
                    addr_d = '0;
                end
            end
            T_RD:  xfer_d = T_LAT;
            T_LAT: xfer_d = T_WR;
            T_WR: begin
                if (SRC_ADDR == LAST_ADDR) begin
                    xfer_d = T_ACK;
                end else begin
                    xfer_d = T_RD;
                    addr_d = SRC_ADDR + 11'd1;
                end
            end
            T_ACK:   xfer_d = T_IDLE;
            default: xfer_d = T_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Sample tick: fractional divider CLK_FREQ -> SAMPLE_RATE.
    // One extra bit keeps the sum from overflowing before the compare.
    // ------------------------------------------------------------------
    always_comb begin
        acc_sum = {1'b0, acc_q} + 33'(SAMPLE_RATE);
        tick    = (acc_sum >= 33'(CLK_FREQ));
        acc_d   = tick ? 32'(acc_sum - 33'(CLK_FREQ)) : acc_sum[31:0];
    end

    // ------------------------------------------------------------------
    // Registers; every output is registered from the next-state values.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            mode_q       <= M_STOPPED;
            xfer_q       <= T_IDLE;
            SRC_ADDR     <= '0;
            SRC_RD       <= 1'b0;
            FIFO_WRITE   <= 1'b0;
            FIFO_DIN     <= '0;
            SECTOR_ACK   <= 1'b0;
            SECTORS_DONE <= '0;
            CMD_READY    <= 1'b1;
            PLAYING      <= 1'b0;
            FIFO_nRESET  <= 1'b0;
            FIFO_READ    <= 1'b0;
            acc_q        <= '0;
        end else begin
            mode_q     <= mode_d;
            xfer_q     <= xfer_d;
            SRC_ADDR   <= addr_d;
            SRC_RD     <= (xfer_d == T_RD);
            FIFO_WRITE <= (xfer_d == T_WR);
            SECTOR_ACK <= (xfer_d == T_ACK);
            if (xfer_q == T_LAT)
                FIFO_DIN <= SRC_DATA;
            if ((xfer_q == T_WR) && (xfer_d == T_ACK))
                SECTORS_DONE <= SECTORS_DONE + 16'd1;
            CMD_READY   <= (mode_d != M_STOPPING);
            PLAYING     <= (mode_d == M_PLAYING);
            // One-cycle flush on each entry into STOPPED.
            FIFO_nRESET <= !((mode_d == M_STOPPED) && (mode_q != M_STOPPED));
            // Next-state mode so a pause on a tick edge suppresses the read.
            FIFO_READ   <= tick && (mode_d == M_PLAYING);
            acc_q       <= acc_d;
        end
    end

endmodule

// File: tb/tb_cdda_ctrl.sv
module tb_cdda_ctrl;

  localparam int unsigned CF_P = 96000000;
  localparam int unsigned SR_P = 44100;
  localparam longint CF = 64'(CF_P);
  localparam longint SR = 64'(SR_P);
  localparam int WORDS = 1176;

  localparam int M_STOP  = 0;
  localparam int M_PLAY  = 1;
  localparam int M_PAUSE = 2;

  // ---------------- clock / reset ----------------
  logic        CLK = 1'b0;
  logic        nRESET = 1'b0;
  always #5 CLK = ~CLK;

  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd = 2'b00;
  logic        sector_valid = 1'b0;
  logic [15:0] src_data = 16'h0;
  logic        fifo_write_ready = 1'b1;

  logic        CMD_READY, SECTOR_ACK, SRC_RD, FIFO_WRITE, FIFO_READ;
  logic        FIFO_nRESET, PLAYING;
  logic [10:0] SRC_ADDR;
  logic [15:0] FIFO_DIN, SECTORS_DONE;

  cdda_ctrl #(.CLK_FREQ(CF_P), .SAMPLE_RATE(SR_P)) dut (
    .CLK(CLK), .nRESET(nRESET),
    .CMD_VALID(cmd_valid), .CMD(cmd), .CMD_READY(CMD_READY),
    .SECTOR_VALID(sector_valid), .SECTOR_ACK(SECTOR_ACK),
    .SRC_RD(SRC_RD), .SRC_ADDR(SRC_ADDR), .SRC_DATA(src_data),
    .FIFO_WRITE(FIFO_WRITE), .FIFO_DIN(FIFO_DIN),
    .FIFO_WRITE_READY(fifo_write_ready), .FIFO_READ(FIFO_READ),
    .FIFO_nRESET(FIFO_nRESET), .PLAYING(PLAYING),
    .SECTORS_DONE(SECTORS_DONE)
  );

  // ---------------- scoreboard / model state ----------------
  logic [15:0] mem [0:WORDS-1];
  logic [15:0] exp_q[$];
  int          err_cnt = 0;
  int          chk_cnt = 0;
  longint      n = 0;
  int          exp_mode = M_STOP;
  logic [15:0] exp_done = 16'd0;
  bit          reload = 1'b0;
  bit          rand_ready = 1'b0;
  bit          in_sec = 1'b0;
  bit          prev_rd = 1'b0;
  bit          prev_ack = 1'b0;
  logic [10:0] prev_addr = 11'd0;
  int          sec_words = 0;
  int          wr_total = 0;
  int          wr_gap = 3;
  int          rd_cnt = 0;
  int          src_rd_cnt = 0;
  int          flush_cnt = 0;
  int          ack_cnt = 0;
  longint      first_rd_n = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0d expected=%0d (edge %0d)", tag, got, exp, n);
    end
  endtask

  // True when the sample clock k*SR/CF crosses an integer at edge k.
  function automatic bit crossed(input longint k);
    return ((k * SR) / CF) != (((k - 1) * SR) / CF);
  endfunction

  task automatic apply_cmd(input logic [1:0] c);
    case (c)
      2'b01: if (exp_mode == M_STOP || exp_mode == M_PAUSE) exp_mode = M_PLAY;
      2'b10: if (exp_mode == M_PLAY) exp_mode = M_PAUSE;
      2'b11: if (exp_mode == M_PAUSE) exp_mode = M_PLAY;
      default: if (exp_mode == M_PLAY || exp_mode == M_PAUSE) exp_mode = M_STOP;
    endcase
  endtask

  // ---------------- driver tasks ----------------
  task automatic offer();
    for (int i = 0; i < WORDS; i++) begin
      mem[i] = 16'($urandom);
      exp_q.push_back(mem[i]);
    end
    sector_valid = 1'b1;
  endtask

  // One clock: advance, then sample outputs away from the edge.
  task automatic step();
    logic       cv;
    logic [1:0] c;
    cv = cmd_valid;
    c  = cmd;
    @(posedge CLK);
    #1;
    if (nRESET) begin
      n++;
      if (cv) apply_cmd(c);
    end else begin
      n = 0;
      exp_mode = M_STOP;
    end
    // source buffer responds the cycle after a read, garbage otherwise
    src_data = (prev_rd && prev_addr < 11'(WORDS)) ? mem[prev_addr] : 16'($urandom);
    prev_rd   = SRC_RD;
    prev_addr = SRC_ADDR;

    check_eq("fifo_read", 32'(FIFO_READ), 32'(nRESET && crossed(n) && exp_mode == M_PLAY));
    check_eq("playing", 32'(PLAYING), 32'(exp_mode == M_PLAY));

    if (FIFO_READ) begin
      rd_cnt++;
      if (first_rd_n == 0) first_rd_n = n;
    end
    if (SRC_RD) src_rd_cnt++;
    if (nRESET && !FIFO_nRESET) flush_cnt++;

    wr_gap++;
    if (FIFO_WRITE) begin
      check_eq("wr_gap", 32'(wr_gap >= 3), 32'd1);
      wr_gap = 0;
      wr_total++;
      sec_words++;
      in_sec = 1'b1;
      if (exp_q.size() > 0) check_eq("wr_data", 32'(FIFO_DIN), 32'(exp_q.pop_front()));
      else check_eq("wr_unexpected", 32'(FIFO_WRITE), 32'd0);
    end

    if (prev_ack) check_eq("sectors_done", 32'(SECTORS_DONE), 32'(exp_done));
    prev_ack = SECTOR_ACK;
    if (SECTOR_ACK) begin
      ack_cnt++;
      check_eq("sector_words", 32'(sec_words), 32'(WORDS));
      exp_done  = exp_done + 16'd1;
      sec_words = 0;
      in_sec    = 1'b0;
      fifo_write_ready = 1'b1;
      if (reload) offer();
      else sector_valid = 1'b0;
    end else if (rand_ready && in_sec) begin
      fifo_write_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic issue(input logic [1:0] c);
    cmd = c;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ack(input int budget, input string tag);
    int start;
    int k;
    start = ack_cnt;
    k = 0;
    while (ack_cnt == start && k < budget) begin
      step();
      k++;
    end
    check_eq(tag, 32'(ack_cnt - start), 32'd1);
  endtask

  task automatic wait_words(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (sec_words != target && k < budget) begin
      step();
      k++;
    end
    check_eq(tag, 32'(sec_words), 32'(target));
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_fifo_nreset"}, 32'(FIFO_nRESET), 32'd0);
    check_eq({tag, "_cmd_ready"}, 32'(CMD_READY), 32'd1);
    check_eq({tag, "_playing"}, 32'(PLAYING), 32'd0);
    check_eq({tag, "_strobes"}, {28'd0, SRC_RD, FIFO_WRITE, FIFO_READ, SECTOR_ACK}, 32'd0);
    check_eq({tag, "_src_addr"}, 32'(SRC_ADDR), 32'd0);
    check_eq({tag, "_fifo_din"}, 32'(FIFO_DIN), 32'd0);
    check_eq({tag, "_sectors_done"}, 32'(SECTORS_DONE), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int base_rd;
    int base_wr;
    int k;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    nRESET = 1'b1;
    n = 0;
    check_reset_values("reset");

    step();
    check_eq("fifo_nreset_release", 32'(FIFO_nRESET), 32'd1);
    repeat (8) step();

    // Backpressure: sector present but FIFO full, play at edge 10.
    fifo_write_ready = 1'b0;
    offer();
    issue(2'b01);
    src_rd_cnt = 0;
    repeat (20) step();
    check_eq("bp_no_rd", 32'(src_rd_cnt), 32'd0);
    fifo_write_ready = 1'b1;
    step();
    check_eq("bp_rd_start", 32'(SRC_RD), 32'd1);

    // Sector fill with FIFO ready toggling mid-sector (must be ignored).
    rand_ready = 1'b1;
    wait_ack(5000, "fill_ack");
    step();
    check_eq("fill_sectors_done", 32'(SECTORS_DONE), 32'd1);
    check_eq("first_read_edge", 32'(first_rd_n), 32'd2177);

    // Pause: transfers continue, no sample reads.
    reload = 1'b1;
    offer();
    issue(2'b10);
    base_rd = rd_cnt;
    base_wr = wr_total;
    repeat (10000) step();
    check_eq("pause_no_read", 32'(rd_cnt - base_rd), 32'd0);
    check_eq("pause_xfer_continues", 32'(wr_total - base_wr > 2 * WORDS), 32'd1);

    // Resume: reads come back on the free-running accumulator phase.
    issue(2'b11);
    base_rd = rd_cnt;
    repeat (5000) step();
    check_eq("resume_reads", 32'(rd_cnt - base_rd >= 2), 32'd1);

    // Pause issued on the very edge of a tick suppresses that read.
    k = 0;
    while (!crossed(n + 1) && k < 3000) begin
      step();
      k++;
    end
    issue(2'b10);
    check_eq("pause_on_tick", 32'(FIFO_READ), 32'd0);
    repeat (3) step();
    issue(2'b11);

    // Stop mid-sector at word 500.
    reload = 1'b0;
    wait_ack(4000, "drain_ack");
    offer();
    wait_words(500, 4000, "stop_at_word");
    issue(2'b00);
    check_eq("stopping_cmd_ready", 32'(CMD_READY), 32'd0);
    flush_cnt = 0;
    wait_ack(3000, "stop_ack");
    check_eq("no_flush_mid_sector", 32'(flush_cnt), 32'd0);
    repeat (3) step();
    check_eq("stopped_cmd_ready", 32'(CMD_READY), 32'd1);
    check_eq("flush_pulse", 32'(flush_cnt), 32'd1);
    repeat (5) step();
    check_eq("flush_single", 32'(flush_cnt), 32'd1);

    // Asynchronous reset in the middle of a sector.
    offer();
    issue(2'b01);
    wait_words(300, 3000, "reset_at_word");
    nRESET = 1'b0;
    #1;
    check_reset_values("async");
    exp_mode = M_STOP;
    exp_done = 16'd0;
    exp_q.delete();
    sec_words = 0;
    in_sec = 1'b0;
    prev_ack = 1'b0;
    fifo_write_ready = 1'b1;
    repeat (3) step();
    @(negedge CLK);
    nRESET = 1'b1;
    n = 0;
    check_eq("rerelease_fifo_nreset", 32'(FIFO_nRESET), 32'd0);
    src_rd_cnt = 0;
    base_wr = wr_total;
    repeat (50) step();
    check_eq("post_reset_no_rd", 32'(src_rd_cnt), 32'd0);
    check_eq("post_reset_no_write", 32'(wr_total - base_wr), 32'd0);
    check_eq("post_reset_sectors_done", 32'(SECTORS_DONE), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
